// File: rtl/ula_arbiter_if.sv
// ula_arbiter_if: requester, ALU and status signals of the ALU arbiter.
// The slave modport is the arbiter side, master is the environment side.
interface ula_arbiter_if;
   logic       clear;
   logic       req0;
   logic       req1;
   logic [2:0] A0;
   logic [2:0] B0;
   logic [2:0] OP0;
   logic [2:0] A1;
   logic [2:0] B1;
   logic [2:0] OP1;
   logic       ack0;
   logic       ack1;
   logic [5:0] result;
   logic       led_zero;
   logic       led_neg;
   logic       led_ovf;
   logic [2:0] alu_A;
   logic [2:0] alu_B;
   logic [2:0] alu_OP;
   logic [5:0] alu_res;
   logic       alu_zero;
   logic       alu_neg;
   logic       alu_ovf;
   logic       busy;
   logic       last_grant;

   modport slave (
      input  clear, req0, req1,
      input  A0, B0, OP0, A1, B1, OP1,
      input  alu_res, alu_zero, alu_neg, alu_ovf,
      output ack0, ack1, result,
      output led_zero, led_neg, led_ovf,
      output alu_A, alu_B, alu_OP,
      output busy, last_grant
   );

   modport master (
      output clear, req0, req1,
      output A0, B0, OP0, A1, B1, OP1,
      output alu_res, alu_zero, alu_neg, alu_ovf,
      input  ack0, ack1, result,
      input  led_zero, led_neg, led_ovf,
      input  alu_A, alu_B, alu_OP,
      input  busy, last_grant
   );
endinterface

// File: rtl/ula_arbiter.sv
// ula_arbiter: round-robin sharing of one combinational 3-bit ALU
// between two requesters, with registered result, flags and ack.
module ula_arbiter #(
   parameter int SETTLE_CYCLES = 1
) (
   input logic          clk,
   input logic          reset,
   ula_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      DONE
   } state_t;

   localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

   state_t     state;
   logic [3:0] cnt;
   logic       win;

   // Winner of the current IDLE cycle; a tie goes to the other index.
   always_comb begin
      win = bus.req1;
      if (bus.req0 && bus.req1)
         win = ~bus.last_grant;
   end

   // Arbitration FSM with registered operands, result, flags and acks.
   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= IDLE;
         cnt            <= 4'd0;
         bus.ack0       <= 1'b0;
         bus.ack1       <= 1'b0;
         bus.busy       <= 1'b0;
         bus.result     <= 6'd0;
         bus.led_zero   <= 1'b0;
         bus.led_neg    <= 1'b0;
         bus.led_ovf    <= 1'b0;
         bus.alu_A      <= 3'd0;
         bus.alu_B      <= 3'd0;
         bus.alu_OP     <= 3'd0;
         bus.last_grant <= 1'b1;
      end else begin
         unique case (state)
            IDLE: begin
               bus.ack0 <= 1'b0;
               bus.ack1 <= 1'b0;
               if (bus.clear) begin
                  bus.result   <= 6'd0;
                  bus.led_zero <= 1'b0;
                  bus.led_neg  <= 1'b0;
                  bus.led_ovf  <= 1'b0;
               end
               if (bus.req0 || bus.req1) begin
                  bus.alu_A      <= win ? bus.A1  : bus.A0;
                  bus.alu_B      <= win ? bus.B1  : bus.B0;
                  bus.alu_OP     <= win ? bus.OP1 : bus.OP0;
                  bus.last_grant <= win;
                  cnt            <= CNT_LOAD;
                  bus.busy       <= 1'b1;
                  state          <= ISSUE;
               end
            end
            ISSUE: begin
               if (cnt == 4'd0) begin
                  bus.result   <= bus.alu_res;
                  bus.led_zero <= bus.alu_zero;
                  bus.led_neg  <= bus.alu_neg;
                  bus.led_ovf  <= bus.alu_ovf;
                  bus.ack0     <= ~bus.last_grant;
                  bus.ack1     <= bus.last_grant;
                  state        <= DONE;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            DONE: begin
               bus.ack0 <= 1'b0;
               bus.ack1 <= 1'b0;
               bus.busy <= 1'b0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ula_arbiter.sv
// tb_ula_arbiter: directed checks of the ALU arbiter with
// settle times of 1 (instance a) and 4 (instance b).
module tb_ula_arbiter;

   logic clk = 1'b0;
   logic rst_a;
   logic rst_b;
   int   checks = 0;
   int   errors = 0;

   ula_arbiter_if ia ();
   ula_arbiter_if ib ();

   ula_arbiter #(.SETTLE_CYCLES(1)) dut_a (
      .clk   (clk),
      .reset (rst_a),
      .bus   (ia.slave)
   );

   ula_arbiter #(.SETTLE_CYCLES(4)) dut_b (
      .clk   (clk),
      .reset (rst_b),
      .bus   (ib.slave)
   );

   always #5 clk = ~clk;

   assign ia.alu_res  = {3'b0, ia.alu_A} + {3'b0, ia.alu_B};
   assign ia.alu_zero = (ia.alu_res == 6'd0);
   assign ia.alu_neg  = 1'b0;
   assign ia.alu_ovf  = 1'b0;
   assign ib.alu_res  = {3'b0, ib.alu_A} + {3'b0, ib.alu_B};
   assign ib.alu_zero = (ib.alu_res == 6'd0);
   assign ib.alu_neg  = 1'b0;
   assign ib.alu_ovf  = 1'b0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   initial begin
      rst_a = 1'b1;
      rst_b = 1'b1;
      ia.clear = 0; ia.req0 = 0; ia.req1 = 0;
      ia.A0 = 0; ia.B0 = 0; ia.OP0 = 0;
      ia.A1 = 0; ia.B1 = 0; ia.OP1 = 0;
      ib.clear = 0; ib.req0 = 0; ib.req1 = 0;
      ib.A0 = 0; ib.B0 = 0; ib.OP0 = 0;
      ib.A1 = 0; ib.B1 = 0; ib.OP1 = 0;
      tick();
      tick();
      chk("rst_result", 8'(ia.result), 8'd0);
      chk("rst_ack0", 8'(ia.ack0), 8'd0);
      chk("rst_busy", 8'(ia.busy), 8'd0);
      chk("rst_lg", 8'(ia.last_grant), 8'd1);
      chk("rst_aluA", 8'(ia.alu_A), 8'd0);
      chk("rst_zero", 8'(ia.led_zero), 8'd0);
      rst_a = 1'b0;
      rst_b = 1'b0;
      tick();

      // single request, settle 1
      ia.A0 = 3; ia.B0 = 4; ia.OP0 = 2; ia.req0 = 1;
      chk("s_c0_busy", 8'(ia.busy), 8'd0);
      tick();
      chk("s_c1_busy", 8'(ia.busy), 8'd1);
      chk("s_c1_ack0", 8'(ia.ack0), 8'd0);
      chk("s_c1_aluA", 8'(ia.alu_A), 8'd3);
      chk("s_c1_aluB", 8'(ia.alu_B), 8'd4);
      chk("s_c1_aluOP", 8'(ia.alu_OP), 8'd2);
      tick();
      chk("s_c2_ack0", 8'(ia.ack0), 8'd1);
      chk("s_c2_ack1", 8'(ia.ack1), 8'd0);
      chk("s_c2_res", 8'(ia.result), 8'd7);
      chk("s_c2_zero", 8'(ia.led_zero), 8'd0);
      chk("s_c2_busy", 8'(ia.busy), 8'd1);
      ia.req0 = 0;
      tick();
      chk("s_c3_ack0", 8'(ia.ack0), 8'd0);
      chk("s_c3_busy", 8'(ia.busy), 8'd0);
      chk("s_c3_res", 8'(ia.result), 8'd7);
      chk("s_c3_lg", 8'(ia.last_grant), 8'd0);

      // clear in IDLE
      ia.clear = 1;
      tick();
      ia.clear = 0;
      chk("clr_res", 8'(ia.result), 8'd0);
      chk("clr_busy", 8'(ia.busy), 8'd0);

      // fairness from reset
      rst_a = 1'b1;
      tick();
      rst_a = 1'b0;
      ia.A0 = 1; ia.B0 = 1; ia.A1 = 5; ia.B1 = 2;
      ia.req0 = 1; ia.req1 = 1;
      tick();
      tick();
      chk("f1_ack0", 8'(ia.ack0), 8'd1);
      chk("f1_ack1", 8'(ia.ack1), 8'd0);
      chk("f1_res", 8'(ia.result), 8'd2);
      tick();
      chk("f_gap_ack0", 8'(ia.ack0), 8'd0);
      chk("f_gap_ack1", 8'(ia.ack1), 8'd0);
      tick();
      tick();
      chk("f2_ack0", 8'(ia.ack0), 8'd0);
      chk("f2_ack1", 8'(ia.ack1), 8'd1);
      chk("f2_res", 8'(ia.result), 8'd7);
      tick();
      tick();
      tick();
      chk("f3_ack0", 8'(ia.ack0), 8'd1);
      chk("f3_ack1", 8'(ia.ack1), 8'd0);
      chk("f3_res", 8'(ia.result), 8'd2);
      ia.req0 = 0; ia.req1 = 0;
      tick();
      tick();
      chk("f_idle_busy", 8'(ia.busy), 8'd0);
      chk("f_idle_ack0", 8'(ia.ack0), 8'd0);

      // clear during ISSUE ignored, req0 dropped during ISSUE
      ia.A0 = 6; ia.B0 = 0; ia.req0 = 1;
      tick();
      ia.clear = 1;
      ia.req0 = 0;
      tick();
      ia.clear = 0;
      chk("ci_ack0", 8'(ia.ack0), 8'd1);
      chk("ci_res", 8'(ia.result), 8'd6);
      tick();
      chk("ci_ack_end", 8'(ia.ack0), 8'd0);
      chk("ci_busy_end", 8'(ia.busy), 8'd0);

      // settle 4, operand change after grant
      chk("b_rst_lg", 8'(ib.last_grant), 8'd1);
      ib.A1 = 0; ib.B1 = 0; ib.OP1 = 5; ib.req1 = 1;
      tick();
      chk("b_c1_aluA", 8'(ib.alu_A), 8'd0);
      ib.A1 = 7;
      for (int c = 2; c <= 4; c++) begin
         tick();
         chk("b_issue_ack1", 8'(ib.ack1), 8'd0);
         chk("b_issue_aluA", 8'(ib.alu_A), 8'd0);
         chk("b_issue_busy", 8'(ib.busy), 8'd1);
      end
      tick();
      chk("b_c5_ack1", 8'(ib.ack1), 8'd1);
      chk("b_c5_ack0", 8'(ib.ack0), 8'd0);
      chk("b_c5_res", 8'(ib.result), 8'd0);
      chk("b_c5_zero", 8'(ib.led_zero), 8'd1);
      chk("b_c5_aluA", 8'(ib.alu_A), 8'd0);
      chk("b_c5_aluOP", 8'(ib.alu_OP), 8'd5);
      ib.req1 = 0;
      tick();
      chk("b_c6_ack1", 8'(ib.ack1), 8'd0);
      chk("b_c6_busy", 8'(ib.busy), 8'd0);

      // nonzero result, then reset in second ISSUE cycle
      ib.A0 = 2; ib.B0 = 3; ib.req0 = 1;
      for (int c = 1; c <= 5; c++) tick();
      chk("r_pre_ack0", 8'(ib.ack0), 8'd1);
      chk("r_pre_res", 8'(ib.result), 8'd5);
      ib.req0 = 0;
      tick();
      ib.A0 = 1; ib.B0 = 1; ib.req0 = 1;
      tick();
      tick();
      rst_b = 1'b1;
      tick();
      rst_b = 1'b0;
      chk("r_ack0", 8'(ib.ack0), 8'd0);
      chk("r_res", 8'(ib.result), 8'd0);
      chk("r_aluA", 8'(ib.alu_A), 8'd0);
      chk("r_aluB", 8'(ib.alu_B), 8'd0);
      chk("r_busy", 8'(ib.busy), 8'd0);
      chk("r_lg", 8'(ib.last_grant), 8'd1);
      ib.A0 = 4; ib.B0 = 1; ib.A1 = 6; ib.B1 = 6;
      ib.req0 = 1; ib.req1 = 1;
      tick();
      chk("r_tie_lg", 8'(ib.last_grant), 8'd0);
      chk("r_tie_aluA", 8'(ib.alu_A), 8'd4);
      for (int c = 2; c <= 5; c++) tick();
      chk("r_tie_ack0", 8'(ib.ack0), 8'd1);
      chk("r_tie_ack1", 8'(ib.ack1), 8'd0);
      chk("r_tie_res", 8'(ib.result), 8'd5);
      ib.req0 = 0; ib.req1 = 0;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
